// File: rtl/bcd_mod_counter_pkg.sv
`default_nettype none
// ============================================================
// bcd_mod_counter_pkg : shared BCD types and clock moduli
// Rev 1.0
// ============================================================
package bcd_mod_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   MOD_SEC = 60;
  localparam int   MOD_MIN = 60;
  localparam int   MOD_HR  = 24;

  // 8 bits so that out-of-range digits (up to 15/15) never alias below a modulus
  function automatic logic [7:0] bcd_value(input bcd_t t, input bcd_t u);
    return ({4'd0, t} * 8'd10) + {4'd0, u};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter_digit.sv
`default_nettype none
// ============================================================
// bcd_mod_counter_digit : one BCD digit, step up/down or load
// Rev 1.0
// ============================================================
module bcd_mod_counter_digit
  import bcd_mod_counter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  input  logic       up_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  output logic [3:0] q_o,
  output logic       carry_o
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (step_i) begin
      if (up_i) q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q_o     = q_q;
  assign carry_o = step_i & ~ld_i & (up_i ? (q_q == BCD_MAX) : (q_q == 4'd0));

endmodule
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================
// bcd_mod_counter : two-digit BCD up/down counter, modulus MODULUS
// Rev 1.0
// ============================================================
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       ck,
  input  logic       r0,
  input  logic       en,
  input  logic       up,
  input  logic       preset,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_units,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       tc,
  output logic       co,
  output logic       load_err
);

  generate
    if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
      $error("bcd_mod_counter: MODULUS %0d outside 2..100", MODULUS);
    end
  endgenerate

  localparam bcd_t       MAX_TENS  = bcd_t'((MODULUS - 1) / 10);
  localparam bcd_t       MAX_UNITS = bcd_t'((MODULUS - 1) % 10);
  localparam logic [7:0] MOD_V     = 8'(MODULUS);

  logic at_max;
  logic at_zero;
  logic load_ok;
  logic ld_all;
  bcd_t ld_tens_val;
  bcd_t ld_units_val;
  logic units_step;
  logic units_carry;
  logic tens_carry_unused;
  logic load_err_d;
  logic load_err_q;

  assign at_max  = (tens == MAX_TENS) && (units == MAX_UNITS);
  assign at_zero = (tens == 4'd0) && (units == 4'd0);
  assign load_ok = (load_tens <= BCD_MAX) && (load_units <= BCD_MAX) &&
                   (bcd_value(load_tens, load_units) < MOD_V);

  // Wrap at the terminal count is a load of both digits, so digits never pass MODULUS-1
  always_comb begin
    ld_all       = 1'b0;
    ld_tens_val  = 4'd0;
    ld_units_val = 4'd0;
    units_step   = 1'b0;
    load_err_d   = 1'b0;
    if (preset) begin
      ld_all       = 1'b1;
      ld_tens_val  = MAX_TENS;
      ld_units_val = MAX_UNITS;
    end else if (load) begin
      if (load_ok) begin
        ld_all       = 1'b1;
        ld_tens_val  = load_tens;
        ld_units_val = load_units;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (tc) begin
        ld_all       = 1'b1;
        ld_tens_val  = up ? 4'd0 : MAX_TENS;
        ld_units_val = up ? 4'd0 : MAX_UNITS;
      end else begin
        units_step = 1'b1;
      end
    end
  end

  bcd_mod_counter_digit u_units (
    .clk_i    (ck),
    .rst_i    (r0),
    .step_i   (units_step),
    .up_i     (up),
    .ld_i     (ld_all),
    .ld_val_i (ld_units_val),
    .q_o      (units),
    .carry_o  (units_carry)
  );

  bcd_mod_counter_digit u_tens (
    .clk_i    (ck),
    .rst_i    (r0),
    .step_i   (units_carry),
    .up_i     (up),
    .ld_i     (ld_all),
    .ld_val_i (ld_tens_val),
    .q_o      (tens),
    .carry_o  (tens_carry_unused)
  );

  always_ff @(posedge ck or posedge r0) begin
    if (r0) load_err_q <= 1'b0;
    else    load_err_q <= load_err_d;
  end

  assign tc       = up ? at_max : at_zero;
  assign co       = en & tc;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================
// tb_bcd_mod_counter : random + directed check against an integer model
// Rev 1.0
// ============================================================
module tb_bcd_mod_counter;

  logic       ck = 1'b0;
  logic       r0 = 1'b1;
  logic       en = 1'b0, up = 1'b1, preset = 1'b0, load = 1'b0;
  logic [3:0] lt = 4'd0, lu = 4'd0;

  logic [3:0] t60, u60, t24, u24, tcs, ucs;
  logic       tc60, co60, le60, tc24, co24, le24, tccs, cocs, lecs;

  int checks = 0;
  int errors = 0;

  // model state: plain integer counts
  int m60 = 0, m24 = 0, mcs = 0;
  bit e60 = 0, e24 = 0, ecs = 0;
  bit mco24;

  always #5 ck = ~ck;

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .ck(ck), .r0(r0), .en(en), .up(up), .preset(preset), .load(load),
    .load_tens(lt), .load_units(lu), .tens(t60), .units(u60),
    .tc(tc60), .co(co60), .load_err(le60));

  bcd_mod_counter #(.MODULUS(24)) u_hr (
    .ck(ck), .r0(r0), .en(en), .up(up), .preset(preset), .load(load),
    .load_tens(lt), .load_units(lu), .tens(t24), .units(u24),
    .tc(tc24), .co(co24), .load_err(le24));

  bcd_mod_counter #(.MODULUS(100)) u_casc (
    .ck(ck), .r0(r0), .en(co24), .up(1'b1), .preset(1'b0), .load(1'b0),
    .load_tens(4'd0), .load_units(4'd0), .tens(tcs), .units(ucs),
    .tc(tccs), .co(cocs), .load_err(lecs));

  function automatic void mstep(input int m, inout int cnt, inout bit lerr,
                                input bit ien, input bit iup, input bit ipre,
                                input bit ild, input int ilt, input int ilu);
    lerr = 1'b0;
    if (ipre) cnt = m - 1;
    else if (ild) begin
      if (ilt <= 9 && ilu <= 9 && ilt * 10 + ilu < m) cnt = ilt * 10 + ilu;
      else lerr = 1'b1;
    end else if (ien) cnt = iup ? (cnt + 1) % m : (cnt + m - 1) % m;
  endfunction

  always @(posedge ck or posedge r0) begin
    if (r0) begin
      m60 = 0; m24 = 0; mcs = 0; e60 = 0; e24 = 0; ecs = 0;
    end else begin
      mco24 = en && (up ? (m24 == 23) : (m24 == 0));
      mstep(60, m60, e60, en, up, preset, load, int'(lt), int'(lu));
      mstep(24, m24, e24, en, up, preset, load, int'(lt), int'(lu));
      mstep(100, mcs, ecs, mco24, 1'b1, 1'b0, 1'b0, 0, 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string n, input int m, input int cnt, input bit lerr,
                          input bit ien, input bit iup, input logic [3:0] t,
                          input logic [3:0] u, input logic tcv, input logic cov,
                          input logic lev);
    bit etc;
    etc = iup ? (cnt == m - 1) : (cnt == 0);
    chk({n, ".tens"}, int'(t), cnt / 10);
    chk({n, ".units"}, int'(u), cnt % 10);
    chk({n, ".tc"}, int'(tcv), int'(etc));
    chk({n, ".co"}, int'(cov), int'(ien && etc));
    chk({n, ".load_err"}, int'(lev), int'(lerr));
  endtask

  always @(negedge ck) begin
    chk_inst("sec", 60, m60, e60, en, up, t60, u60, tc60, co60, le60);
    chk_inst("hr", 24, m24, e24, en, up, t24, u24, tc24, co24, le24);
    chk_inst("casc", 100, mcs, ecs, mco24, 1'b1, tcs, ucs, tccs, cocs, lecs);
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input bit ien, input bit iup, input bit ipre, input bit ild,
                       input int ilt, input int ilu);
    en = ien; up = iup; preset = ipre; load = ild;
    lt = 4'(ilt); lu = 4'(ilu);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) tick();
    r0 = 1'b0;
    chk("reset.tens", int'(t60), 0);
    chk("reset.load_err", int'(le60), 0);

    // reset mid-count at 37 clears before the next edge
    drive(0, 1, 0, 1, 3, 7); tick();
    drive(0, 1, 0, 0, 0, 0);
    chk("load37.tens", int'(t60), 3);
    chk("load37.units", int'(u60), 7);
    chk("hr.reject37", int'(le24), 1);
    #2 r0 = 1'b1;
    #1 chk("async.tens", int'(t60), 0);
    chk("async.units", int'(u60), 0);
    tick(); r0 = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    chk("rel.00", int'(u60), 0);
    tick(); chk("rel.01", int'(u60), 1);
    tick(); chk("rel.02", int'(u60), 2);

    // mod 60 up: load with en set takes no extra step
    drive(1, 1, 0, 1, 5, 8); tick();
    drive(1, 1, 0, 0, 0, 0);
    chk("up.58", int'(t60) * 10 + int'(u60), 58);
    #1 chk("up.58.tc", int'(tc60), 0);
    tick(); chk("up.59", int'(t60) * 10 + int'(u60), 59);
    chk("up.59.tc", int'(tc60), 1);
    chk("up.59.co", int'(co60), 1);
    tick(); chk("up.wrap", int'(t60) * 10 + int'(u60), 0);
    chk("up.wrap.tc", int'(tc60), 0);
    drive(0, 1, 0, 1, 0, 9); tick();
    drive(1, 1, 0, 0, 0, 0); tick();
    chk("up.carry10", int'(t60) * 10 + int'(u60), 10);

    // mod 60 down
    drive(0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    #1 chk("dn.00.tc", int'(tc60), 1);
    chk("dn.00.co", int'(co60), 1);
    tick(); chk("dn.wrap59", int'(t60) * 10 + int'(u60), 59);
    drive(0, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick();
    chk("dn.borrow09", int'(t60) * 10 + int'(u60), 9);

    // mod 24 preset and cascade
    drive(0, 1, 1, 0, 0, 0); tick();
    chk("hr.preset23", int'(t24) * 10 + int'(u24), 23);
    drive(1, 1, 0, 0, 0, 0);
    #1 chk("hr.23.co", int'(co24), 1);
    c0 = mcs;
    tick(); chk("hr.wrap", int'(t24) * 10 + int'(u24), 0);
    chk("casc.step", int'(tcs) * 10 + int'(ucs), (c0 + 1) % 100);

    // load validation at mod 24
    drive(0, 1, 1, 0, 0, 0); tick();
    drive(0, 1, 0, 1, 2, 4); tick();
    chk("hr.rej24.cnt", int'(t24) * 10 + int'(u24), 23);
    chk("hr.rej24.err", int'(le24), 1);
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("hr.err.pulse", int'(le24), 0);
    drive(1, 1, 0, 1, 1, 10); tick();
    chk("hr.rej1_10.cnt", int'(t24) * 10 + int'(u24), 23);
    chk("hr.rej1_10.err", int'(le24), 1);
    drive(0, 1, 0, 1, 1, 9); tick();
    chk("hr.ld19", int'(t24) * 10 + int'(u24), 19);
    chk("hr.ld19.err", int'(le24), 0);

    // priority
    drive(1, 1, 1, 1, 0, 5); tick();
    chk("pri.sec", int'(t60) * 10 + int'(u60), 59);
    chk("pri.hr", int'(t24) * 10 + int'(u24), 23);
    chk("pri.err", int'(le24), 0);
    drive(1, 1, 0, 1, 0, 5); tick();
    chk("pri.ld05", int'(t60) * 10 + int'(u60), 5);

    // randomized traffic, including async resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9),
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) begin
        #3 r0 = 1'b1;
        tick();
        r0 = 1'b0;
      end else begin
        tick();
      end
    end

    drive(0, 1, 0, 0, 0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised two-digit synchronous BCD counter with a programmable overall modulus. It is the successor to the 7490-style decade stage in the digital clock datapath. A single instance covers seconds/minutes (mod 60) or hours (mod 24) and adds features the decade stage lacks: up/down counting, synchronous load with validation, preset-to-maximum, and synchronous cascade carry. Instances chain seconds -> minutes -> hours on one clock through en/co.

Parameters:
MODULUS, 60, overall count modulus; legal range 2..100; count sequence is 0..MODULUS-1, held as two BCD digits.

Ports:
ck  input  1  system clock, rising-edge.
r0  input  1  reset, asynchronous, active-high; clears the count to 00.
en  input  1  count enable / cascade carry-in; one step per ck edge while high.
up  input  1  direction: 1 = increment, 0 = decrement.
preset  input  1  synchronous set to MODULUS-1 (generalised "set-to-9").
load  input  1  synchronous parallel load request.
load_tens  input  4  BCD tens digit to load.
load_units  input  4  BCD units digit to load.
tens  output  4  BCD tens digit of the count.
units  output  4  BCD units digit of the count.
tc  output  1  terminal count, combinational: (up and count == MODULUS-1) or (!up and count == 0).
co  output  1  cascade carry-out, combinational: en and tc.
load_err  output  1  registered one-cycle pulse when a load request is rejected.

Behaviour:
- Reset: r0 high forces tens=0, units=0, load_err=0 immediately (asynchronous). Release is synchronous to the next ck edge. Mid-count assertion aborts any action in progress.
- Priority on each ck edge: preset > load > en. Exactly one action per cycle.
- preset: count <= MODULUS-1 (tens = (MODULUS-1)/10, units = (MODULUS-1)%10). Any simultaneous load is ignored and load_err stays 0.
- load: accepted only if load_tens <= 9, load_units <= 9 and 10*load_tens + load_units < MODULUS.
  - Accepted: count takes the loaded value next edge; load_err = 0.
  - Rejected: count unchanged, even if en is high that cycle; load_err = 1 for exactly one cycle.
- en, up=1:
  - At count == MODULUS-1: wrap to 00.
  - Else if units == 9: units <= 0, tens <= tens+1.
  - Else units <= units+1.
- en, up=0:
  - At count == 0: wrap to MODULUS-1.
  - Else if units == 0: units <= 9, tens <= tens-1.
  - Else units <= units-1.
- en low with no preset/load: hold.
- Digits never leave 0..9. The count never reaches or exceeds MODULUS after any legal operation.
- tc and co are combinational with no register latency, so a downstream instance with en tied to this co steps on the same edge this instance wraps.
- Latency: every count change is visible one ck edge after the request. load_err is asserted in the cycle after the rejected request.
- MODULUS outside 2..100 is a static configuration error; the module flags it at elaboration.

Decomposition:
- Shared clock package: BCD digit type (4 bits), constants BCD_MAX=9, MOD_SEC=60, MOD_MIN=60, MOD_HR=24.
- Sub-module bcd_digit: one BCD digit with inc/dec/load/clear controls and a carry/borrow flag.
- Top level: modulus compare, wrap override, load validation, tc/co, load_err register.

Test Plan:
- Reset: r0=1 mid-count at 37 -> tens/units read 0/0 before the next ck edge; after release with en=1, up=1 the sequence is 00,01,02.
- MODULUS=60 up: load 58, en=1 -> 58, 59 (tc=1, co=1), 00 (tc=0); 09 -> 10 digit carry.
- MODULUS=60 down: count 00, up=0, en=1 -> tc=1, co=1; next value 59; 10 -> 09 digit borrow.
- MODULUS=24: preset -> 23; en=1, up=1 -> 00 with co=1 on the 23 cycle. Second instance cascaded from co increments exactly once per wrap.
- Load validation, MODULUS=24:
  - load 2/4 (=24) -> count unchanged, load_err=1 for one cycle.
  - load 1/10 -> rejected, load_err=1.
  - load 1/9 -> count 19, load_err=0.
- Priority: preset=1, load=1 (05), en=1 in the same cycle -> count = MODULUS-1, load_err=0. load=1 with en=1 -> loaded value, with no extra increment.
